wb_arbiter: RTL and testbench

- Writeback arbiter between the execute/memory stages and the 32x64 register file's single write port.
- Merges two result streams: an ALU stream that cannot back-pressure, and a load-unit stream that can.
- Buffers load results in a small FIFO, drops writes to r0, and drives registered write_en/write_address/write_data into the register file.
- Prevents load starvation with a bounded ALU-stall request.

---
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execute/memory stages, the writeback arbiter and the register-file write port.
interface wb_arbiter_if #(
  parameter int unsigned LD_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(LD_DEPTH) + 1;

  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [63:0]      alu_data;
  logic             alu_stall;
  logic             ld_valid;
  logic [4:0]       ld_rd;
  logic [63:0]      ld_data;
  logic             ld_ready;
  logic             write_en;
  logic [4:0]       write_address;
  logic [63:0]      write_data;
  logic [CNT_W-1:0] fifo_count;
  logic             alu_lost_err;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_stall, ld_ready, write_en, write_address, write_data,
           fifo_count, alu_lost_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_stall, ld_ready, write_en, write_address, write_data,
           fifo_count, alu_lost_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU stream and a FIFO-buffered load stream into the
// single register-file write port, with a bounded ALU stall to keep loads from starving.
module wb_arbiter #(
  parameter int unsigned LD_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(LD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LD_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_ALU,
    GRANT_FIFO
  } grant_e;

  entry_t           fifo_q [LD_DEPTH];
  entry_t           fifo_d [LD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             write_en_q, write_en_d;
  logic [4:0]       write_address_q, write_address_d;
  logic [63:0]      write_data_q, write_data_d;
  logic             lost_err_q, lost_err_d;

  logic   fifo_nonempty;
  logic   ld_ready;
  logic   alu_stall;
  logic   enq;
  logic   deq;
  grant_e grant;
  entry_t head;

  always_comb begin
    fifo_nonempty = (count_q != '0);
    ld_ready      = (count_q != FULL_CNT);
    alu_stall     = (starve_q == STARVE_MAX) && fifo_nonempty;
    head          = fifo_q[rd_ptr_q];

    if (alu_stall)          grant = GRANT_FIFO;
    else if (bus.alu_valid) grant = GRANT_ALU;
    else if (fifo_nonempty) grant = GRANT_FIFO;
    else                    grant = GRANT_NONE;

    // r0 loads complete the handshake but never occupy a slot
    enq = bus.ld_valid && ld_ready && (bus.ld_rd != '0);
    deq = (grant == GRANT_FIFO);

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      fifo_d[wr_ptr_q] = '{rd: bus.ld_rd, data: bus.ld_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (!fifo_nonempty || deq)
      starve_d = '0;
    else if ((grant == GRANT_ALU) && (starve_q != STARVE_MAX))
      starve_d = starve_q + SC_W'(1);
    else
      starve_d = starve_q;

    write_en_d      = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    case (grant)
      GRANT_FIFO: begin
        write_en_d      = 1'b1;
        write_address_d = head.rd;
        write_data_d    = head.data;
      end
      GRANT_ALU: begin
        if (bus.alu_rd != '0) begin
          write_en_d      = 1'b1;
          write_address_d = bus.alu_rd;
          write_data_d    = bus.alu_data;
        end
      end
      default: ;
    endcase

    lost_err_d = lost_err_q | (bus.alu_valid && alu_stall);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LD_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      starve_q        <= '0;
      write_en_q      <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      lost_err_q      <= 1'b0;
    end else begin
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      starve_q        <= starve_d;
      write_en_q      <= write_en_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      lost_err_q      <= lost_err_d;
    end
  end

  assign bus.alu_stall     = alu_stall;
  assign bus.ld_ready      = ld_ready;
  assign bus.write_en      = write_en_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.fifo_count    = count_q;
  assign bus.alu_lost_err  = lost_err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_wb_arbiter;
  localparam int unsigned LD_DEPTH     = 4;
  localparam int unsigned STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic reset;
  logic chk_en;
  always #5 clk = ~clk;

  wb_arbiter_if #(.LD_DEPTH(LD_DEPTH)) bus ();

  wb_arbiter #(
    .LD_DEPTH    (LD_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending loads as a queue, starvation as a count of lost cycles
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ld_t;

  ld_t         mq[$];
  int          m_lost;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  logic        m_err;

  function automatic bit m_stall();
    return (m_lost >= STARVE_LIMIT) && (mq.size() != 0);
  endfunction

  function automatic bit m_ready();
    return mq.size() < LD_DEPTH;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_lost = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_err  = 1'b0;
      end else begin
        bit  stall, ready, had, take_fifo, take_alu;
        ld_t h;
        stall     = m_stall();
        ready     = m_ready();
        had       = (mq.size() != 0);
        take_fifo = stall || (!bus.alu_valid && had);
        take_alu  = !take_fifo && bus.alu_valid;
        if (bus.alu_valid && stall) m_err = 1'b1;
        m_we = 1'b0;
        if (take_fifo) begin
          h      = mq.pop_front();
          m_we   = 1'b1;
          m_addr = h.rd;
          m_data = h.data;
          m_lost = 0;
        end else if (take_alu) begin
          if (bus.alu_rd != 5'd0) begin
            m_we   = 1'b1;
            m_addr = bus.alu_rd;
            m_data = bus.alu_data;
          end
          if (had) m_lost = (m_lost < STARVE_LIMIT) ? m_lost + 1 : m_lost;
          else     m_lost = 0;
        end else begin
          m_lost = 0;
        end
        if (bus.ld_valid && ready && (bus.ld_rd != 5'd0))
          mq.push_back('{rd: bus.ld_rd, data: bus.ld_data});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !reset) begin
        check("cyc.write_en",      64'(bus.write_en),      64'(m_we));
        check("cyc.write_address", 64'(bus.write_address), 64'(m_addr));
        check("cyc.write_data",    bus.write_data,         m_data);
        check("cyc.fifo_count",    64'(bus.fifo_count),    64'(mq.size()));
        check("cyc.ld_ready",      64'(bus.ld_ready),      64'(m_ready()));
        check("cyc.alu_stall",     64'(bus.alu_stall),     64'(m_stall()));
        check("cyc.alu_lost_err",  64'(bus.alu_lost_err),  64'(m_err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_alu(input bit v, input logic [4:0] rd, input logic [63:0] d, input bit honour);
    bus.alu_valid = v && !(honour && m_stall());
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic set_ld(input bit v, input logic [4:0] rd, input logic [63:0] d);
    bus.ld_valid = v;
    bus.ld_rd    = rd;
    bus.ld_data  = d;
  endtask

  initial begin
    reset  = 1'b1;
    chk_en = 1'b0;
    set_alu(0, '0, '0, 0);
    set_ld(0, '0, '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst.write_en",      64'(bus.write_en),      64'd0);
    check("rst.write_address", 64'(bus.write_address), 64'd0);
    check("rst.write_data",    bus.write_data,         64'd0);
    check("rst.fifo_count",    64'(bus.fifo_count),    64'd0);
    check("rst.ld_ready",      64'(bus.ld_ready),      64'd1);
    check("rst.alu_stall",     64'(bus.alu_stall),     64'd0);

    // ALU only: 1-cycle latency, r0 suppressed
    tick();
    set_alu(1, 5'd5, 64'h1122334455667788, 0);
    tick();
    set_alu(1, 5'd0, 64'hFFFF_0000_FFFF_0000, 0);
    @(negedge clk);
    check("alu.write_en",   64'(bus.write_en),      64'd1);
    check("alu.write_addr", 64'(bus.write_address), 64'd5);
    check("alu.write_data", bus.write_data,         64'h1122334455667788);
    tick();
    set_alu(0, '0, '0, 0);
    @(negedge clk);
    check("alu_r0.write_en",  64'(bus.write_en),      64'd0);
    check("alu_r0.addr_hold", 64'(bus.write_address), 64'd5);

    // Load path: 2-cycle latency, r0 loads not buffered
    tick();
    set_ld(1, 5'd9, 64'hDEAD);
    tick();
    set_ld(0, '0, '0);
    @(negedge clk);
    check("ld.t1_write_en",   64'(bus.write_en),   64'd0);
    check("ld.t1_fifo_count", 64'(bus.fifo_count), 64'd1);
    tick();
    @(negedge clk);
    check("ld.t2_write_en",   64'(bus.write_en),      64'd1);
    check("ld.t2_write_addr", 64'(bus.write_address), 64'd9);
    check("ld.t2_write_data", bus.write_data,         64'hDEAD);
    tick();
    set_ld(1, 5'd0, 64'hBEEF);
    tick();
    set_ld(0, '0, '0);
    @(negedge clk);
    check("ld_r0.fifo_count", 64'(bus.fifo_count), 64'd0);
    check("ld_r0.write_en",   64'(bus.write_en),   64'd0);

    // FIFO full under continuous ALU traffic, then in-order drain
    tick();
    for (int k = 0; k < 4; k++) begin
      set_ld(1, 5'(k + 1), 64'hA000 + 64'(k));
      set_alu(1, 5'(16 + k), 64'hC000 + 64'(k), 1);
      tick();
    end
    set_ld(1, 5'd5, 64'hA004);
    set_alu(1, 5'd20, 64'hC004, 1);
    @(negedge clk);
    check("full.fifo_count", 64'(bus.fifo_count), 64'd4);
    check("full.ld_ready",   64'(bus.ld_ready),   64'd0);
    check("full.alu_stall",  64'(bus.alu_stall),  64'd1);
    tick();
    set_alu(1, 5'd21, 64'hC005, 1);
    @(negedge clk);
    check("full.first_addr", 64'(bus.write_address), 64'd1);
    check("full.first_data", bus.write_data,         64'hA000);
    check("full.ld_ready_1", 64'(bus.ld_ready),      64'd1);
    tick();
    set_ld(0, '0, '0);
    set_alu(0, '0, '0, 0);
    tick();
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("drain.write_addr", 64'(bus.write_address), 64'(k));
      tick();
    end
    @(negedge clk);
    check("drain.fifo_count", 64'(bus.fifo_count), 64'd0);

    // Starvation: one buffered load against a busy ALU
    repeat (2) tick();
    set_ld(1, 5'd7, 64'h7777);
    set_alu(1, 5'd20, 64'h2000, 1);
    tick();
    set_ld(0, '0, '0);
    set_alu(1, 5'd21, 64'h2001, 1);
    @(negedge clk);
    check("starve.c1_count", 64'(bus.fifo_count), 64'd1);
    tick();
    set_alu(1, 5'd22, 64'h2002, 1);
    tick();
    set_alu(1, 5'd23, 64'h2003, 1);
    @(negedge clk);
    check("starve.c3_stall", 64'(bus.alu_stall), 64'd0);
    tick();
    set_alu(1, 5'd24, 64'h2004, 1);
    @(negedge clk);
    check("starve.c4_stall", 64'(bus.alu_stall), 64'd1);
    tick();
    set_alu(0, '0, '0, 0);
    @(negedge clk);
    check("starve.c5_write_en",   64'(bus.write_en),      64'd1);
    check("starve.c5_write_addr", 64'(bus.write_address), 64'd7);
    check("starve.c5_write_data", bus.write_data,         64'h7777);
    check("starve.c5_stall",      64'(bus.alu_stall),     64'd0);

    // Protocol error: ALU result driven during a stall is dropped and flagged
    repeat (2) tick();
    set_ld(1, 5'd8, 64'h8888);
    set_alu(1, 5'd20, 64'h3000, 1);
    tick();
    set_ld(0, '0, '0);
    for (int k = 1; k < 4; k++) begin
      set_alu(1, 5'(20 + k), 64'h3000 + 64'(k), 1);
      tick();
    end
    set_alu(1, 5'd30, 64'hBAD, 0);
    @(negedge clk);
    check("err.pre_flag", 64'(bus.alu_lost_err), 64'd0);
    tick();
    set_alu(0, '0, '0, 0);
    @(negedge clk);
    check("err.flag",       64'(bus.alu_lost_err),  64'd1);
    check("err.write_addr", 64'(bus.write_address), 64'd8);
    tick();
    @(negedge clk);
    check("err.no_lost_write", 64'(bus.write_en), 64'd0);
    tick();
    tick();
    @(negedge clk);
    check("err.sticky", 64'(bus.alu_lost_err), 64'd1);

    // Reset mid-traffic discards buffered loads
    tick();
    for (int k = 0; k < 3; k++) begin
      set_ld(1, 5'(11 + k), 64'hB000 + 64'(k));
      set_alu(1, 5'(1 + k), 64'hD000 + 64'(k), 1);
      tick();
    end
    set_ld(0, '0, '0);
    set_alu(0, '0, '0, 0);
    @(negedge clk);
    check("mid.pre_count", 64'(bus.fifo_count), 64'd3);
    #1 reset = 1'b1;
    #1;
    check("mid.write_en",   64'(bus.write_en),     64'd0);
    check("mid.fifo_count", 64'(bus.fifo_count),   64'd0);
    check("mid.ld_ready",   64'(bus.ld_ready),     64'd1);
    check("mid.err_clear",  64'(bus.alu_lost_err), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid.post_write_en", 64'(bus.write_en),   64'd0);
      check("mid.post_count",    64'(bus.fifo_count), 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
